// File: rtl/rate_decoder.sv
// rate_decoder: decodes the spacing of a pulse stream back into a 2-bit speed mode.
// Define RATE_DECODER_SEG_EN to build a registered seven-segment digit on hex.
module rate_decoder #(
  parameter int CNT_W    = 32,
  parameter int PERIOD_0 = 2,
  parameter int PERIOD_1 = 50000001,
  parameter int PERIOD_2 = 25000001,
  parameter int PERIOD_3 = 12500001,
  parameter int TOL      = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [1:0]       mode,
  output logic             valid,
  output logic             changed,
  output logic [CNT_W-1:0] interval_out,
  output logic [6:0]       hex
);
  typedef enum logic [1:0] {IDLE, ARMED, CONFIRM, LOCKED} state_t;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(PERIOD_1 + TOL + 1);
  localparam int PER [4] = '{PERIOD_0, PERIOD_1, PERIOD_2, PERIOD_3};
  function automatic logic [CNT_W-1:0] lo_of(input int p);
    return (p > TOL) ? CNT_W'(p - TOL) : CNT_W'(1);
  endfunction
  function automatic logic [CNT_W-1:0] hi_of(input int p);
    return CNT_W'(p + TOL);
  endfunction
  state_t           state_q, state_d;
  logic             pulse_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic             evt, hit;
  logic [1:0]       hit_k, ref_k;
  assign evt = pulse_in & ~pulse_prev_q;
  always_comb begin
    hit   = 1'b0;
    hit_k = 2'd0;
    for (int k = 0; k < 4; k++)
      if (cnt_q >= lo_of(PER[k]) && cnt_q <= hi_of(PER[k])) begin
        hit   = 1'b1;
        hit_k = 2'(k);
      end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      pulse_prev_q <= 1'b0;
      cnt_q        <= '0;
      cand_q       <= 2'd0;
      mode_q       <= 2'd0;
      valid_q      <= 1'b0;
      changed_q    <= 1'b0;
      interval_q   <= '0;
    end else begin
      state_q      <= state_d;
      pulse_prev_q <= pulse_in;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      mode_q       <= mode_d;
      valid_q      <= valid_d;
      changed_q    <= changed_d;
      interval_q   <= interval_d;
    end
  // CONFIRM compares against the candidate, LOCKED against the held mode
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    ref_k   = (state_q == LOCKED) ? mode_q : cand_q;
    if (evt && state_q == IDLE)
      state_d = ARMED;
    else if (evt) begin
      cand_d  = hit ? hit_k : cand_q;
      state_d = !hit ? ARMED : (state_q != ARMED && hit_k == ref_k) ? LOCKED : CONFIRM;
    end else if (cnt_q == TIMEOUT)
      state_d = IDLE;
  end
  always_comb begin
    cnt_d      = evt ? CNT_W'(1) : (state_d == IDLE) ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    interval_d = evt ? cnt_q : interval_q;
    valid_d    = state_d == LOCKED;
    changed_d  = state_d == LOCKED && state_q != LOCKED;
    mode_d     = changed_d ? cand_q : mode_q;
  end
  assign mode         = mode_q;
  assign valid        = valid_q;
  assign changed      = changed_q;
  assign interval_out = interval_q;
`ifdef RATE_DECODER_SEG_EN
  logic [6:0] hex_q, hex_d;
  always_comb
    hex_d = !valid_d       ? 7'b1111111 :
            mode_d == 2'd0 ? 7'b1000000 :
            mode_d == 2'd1 ? 7'b1111001 :
            mode_d == 2'd2 ? 7'b0100100 : 7'b0110000;
  always_ff @(posedge clock or posedge reset)
    if (reset) hex_q <= 7'b1111111;
    else       hex_q <= hex_d;
  assign hex = hex_q;
`else
  assign hex = 7'b1111111;
`endif
endmodule

// File: tb/tb_rate_decoder.sv
// tb_rate_decoder: directed checks of lock, relock, timeout, mismatch and async reset.
module tb_rate_decoder;
  logic       clock = 1'b0;
  logic       reset;
  logic       pulse_in;
  logic [1:0] mode;
  logic       valid, changed;
  logic [7:0] interval_out;
  logic [6:0] hex;
  int checks = 0;
  int failures = 0;
  rate_decoder #(.CNT_W(8), .PERIOD_0(2), .PERIOD_1(41), .PERIOD_2(21), .PERIOD_3(11), .TOL(2)) dut (
    .clock(clock), .reset(reset), .pulse_in(pulse_in), .mode(mode), .valid(valid),
    .changed(changed), .interval_out(interval_out), .hex(hex)
  );
  always #5 clock = ~clock;
`ifdef RATE_DECODER_SEG_EN
  localparam logic [6:0] SEG0 = 7'b1000000, SEG1 = 7'b1111001, SEG2 = 7'b0100100, SEG3 = 7'b0110000;
`else
  localparam logic [6:0] SEG0 = 7'b1111111, SEG1 = 7'b1111111, SEG2 = 7'b1111111, SEG3 = 7'b1111111;
`endif
  localparam logic [6:0] BLANK = 7'b1111111;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic ev();
    pulse_in = 1'b1;
    @(posedge clock); #1;
    pulse_in = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic look(input string tag, input logic v, input logic [1:0] m, input logic c,
                      input logic [7:0] iv, input logic [6:0] h);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".mode"}, 32'(mode), 32'(m));
    chk({tag, ".changed"}, 32'(changed), 32'(c));
    chk({tag, ".interval"}, 32'(interval_out), 32'(iv));
    chk({tag, ".hex"}, 32'(hex), 32'(h));
  endtask
  initial begin
    reset = 1'b1;
    pulse_in = 1'b0;
    idle(3);
    look("reset", 0, 0, 0, 0, BLANK);
    reset = 1'b0;
    idle(2);
    ev();
    look("m3_e1", 0, 0, 0, 0, BLANK);
    idle(10); ev();
    look("m3_e2", 0, 0, 0, 11, BLANK);
    idle(10); ev();
    look("m3_lock", 1, 3, 1, 11, SEG3);
    idle(1);
    look("m3_hold", 1, 3, 0, 11, SEG3);
    idle(19); ev();
    look("m2_drop", 0, 3, 0, 21, BLANK);
    idle(20); ev();
    look("m2_lock", 1, 2, 1, 21, SEG2);
    idle(43);
    look("to_before", 1, 2, 0, 21, SEG2);
    idle(1);
    look("to_after", 0, 2, 0, 21, BLANK);
    idle(2); ev();
    look("idle_e1", 0, 2, 0, 0, BLANK);
    idle(40); ev();
    look("i41a", 0, 2, 0, 41, BLANK);
    idle(15); ev();
    look("i16", 0, 2, 0, 16, BLANK);
    idle(40); ev();
    look("i41b", 0, 2, 0, 41, BLANK);
    idle(40); ev();
    look("m1_lock", 1, 1, 1, 41, SEG1);
    idle(3);
    #3 reset = 1'b1;
    #1 look("async_rst", 0, 0, 0, 0, BLANK);
    #2 reset = 1'b0;
    idle(2);
    ev();
    idle(1); ev();
    look("m0_e2", 0, 0, 0, 2, BLANK);
    idle(1); ev();
    look("m0_lock", 1, 0, 1, 2, SEG0);
    idle(1); ev();
    look("m0_hold", 1, 0, 0, 2, SEG0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
